// File: rtl/wheel_motor_driver_pkg.sv
// Shared definitions for the wheel motor driver: channel FSM encoding and
// helpers that derive frame geometry and counter widths from the parameters.
package wheel_motor_driver_pkg;

    typedef enum logic {
        DRIVE = 1'b0,
        DEAD  = 1'b1
    } chan_state_t;

    // Number of duty steps in one frame: largest positive command magnitude.
    function automatic int steps_of(input int width_cmd);
        return (1 << (width_cmd - 1)) - 1;
    endfunction

    // Frame length in clocks.
    function automatic int frame_of(input int width_cmd, input int prescale);
        return steps_of(width_cmd) * prescale;
    endfunction

    // Bits needed to count 0..n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wheel_motor_driver_if.sv
// Bundle between the controller and the motor driver.
// Commands and enable are plain levels (no valid/ready): the driver samples
// the wheel commands only at frame boundaries and reacts to enable every clock.
// state_left/state_right expose the per-wheel FSM state for observation.
interface wheel_motor_driver_if
    import wheel_motor_driver_pkg::*;
#(
    parameter int WIDTH_CMD = 4
);
    logic                 enable;
    logic [WIDTH_CMD-1:0] wheel_left;
    logic [WIDTH_CMD-1:0] wheel_right;
    logic                 pwm_left;
    logic                 pwm_right;
    logic                 dir_left;
    logic                 dir_right;
    logic                 frame_start;
    chan_state_t          state_left;
    chan_state_t          state_right;

    modport master (
        output enable, wheel_left, wheel_right,
        input  pwm_left, pwm_right, dir_left, dir_right, frame_start,
        input  state_left, state_right
    );

    modport slave (
        input  enable, wheel_left, wheel_right,
        output pwm_left, pwm_right, dir_left, dir_right, frame_start,
        output state_left, state_right
    );
endinterface

// File: rtl/wheel_motor_driver_channel.sv
// One wheel: samples the signed command at frame boundaries, saturates its
// magnitude, inserts dead frames on direction reversal, and compares the
// latched duty against the shared step counter to produce PWM.
module wheel_pwm_channel
    import wheel_motor_driver_pkg::*;
#(
    parameter int WIDTH_CMD       = 4,
    parameter int DEADTIME_FRAMES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sample,
    input  logic [WIDTH_CMD-2:0] step,
    input  logic [WIDTH_CMD-1:0] cmd,
    output logic                 pwm,
    output logic                 dir,
    output chan_state_t          state
);
    localparam int MW = WIDTH_CMD - 1;
    localparam int DW = cnt_width(DEADTIME_FRAMES + 1);
    localparam logic [MW-1:0]        MAG_MAX  = {MW{1'b1}};
    localparam logic [WIDTH_CMD-1:0] MOST_NEG = {1'b1, {MW{1'b0}}};

    logic                 cmd_neg;
    logic [WIDTH_CMD-1:0] cmd_negated;
    logic [MW-1:0]        cmd_mag;
    logic                 opposes;
    logic [MW-1:0]        mag_q;
    logic [DW-1:0]        dead_cnt;

    // Magnitude of the live command (most-negative code saturates) and
    // whether it asks for the opposite direction.
    always_comb begin
        cmd_neg     = cmd[WIDTH_CMD-1];
        cmd_negated = -cmd;
        if (cmd == MOST_NEG) begin
            cmd_mag = MAG_MAX;
        end else if (cmd_neg) begin
            cmd_mag = cmd_negated[MW-1:0];
        end else begin
            cmd_mag = cmd[MW-1:0];
        end
        opposes = (cmd_mag != '0) && (cmd_neg != dir);
    end

    // Channel FSM with registered pwm/dir. On a sample edge the step counter
    // is 0, so "new duty nonzero" is the first-cycle compare.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= DRIVE;
            dir      <= 1'b0;
            pwm      <= 1'b0;
            mag_q    <= '0;
            dead_cnt <= '0;
        end else if (sample) begin
            case (state)
                DRIVE: begin
                    if (opposes) begin
                        state    <= DEAD;
                        dead_cnt <= DW'(DEADTIME_FRAMES);
                        mag_q    <= '0;
                        pwm      <= 1'b0;
                    end else begin
                        mag_q <= cmd_mag;
                        pwm   <= enable && (cmd_mag != '0);
                    end
                end
                DEAD: begin
                    if (dead_cnt <= DW'(1)) begin
                        dead_cnt <= '0;
                        state    <= DRIVE;
                        if (opposes) begin
                            dir <= ~dir;
                        end
                        mag_q <= cmd_mag;
                        pwm   <= enable && (cmd_mag != '0);
                    end else begin
                        dead_cnt <= dead_cnt - DW'(1);
                        pwm      <= 1'b0;
                    end
                end
                default: begin
                    state <= DRIVE;
                    pwm   <= 1'b0;
                end
            endcase
        end else begin
            pwm <= enable && (state == DRIVE) && (mag_q > step);
        end
    end

endmodule

// File: rtl/wheel_motor_driver.sv
// Two-wheel PWM motor driver: shared prescale/step counters define the frame,
// and each wheel is handled by an independent wheel_pwm_channel.
module wheel_motor_driver
    import wheel_motor_driver_pkg::*;
#(
    parameter int WIDTH_CMD       = 4,
    parameter int PRESCALE        = 256,
    parameter int DEADTIME_FRAMES = 1
) (
    input logic                clk,
    input logic                reset,
    wheel_motor_driver_if.slave bus
);
    localparam int STEPS = steps_of(WIDTH_CMD);
    localparam int PW    = cnt_width(PRESCALE);
    localparam int SW    = WIDTH_CMD - 1;

    logic [PW-1:0] presc;
    logic [SW-1:0] step;
    logic          sample;
    logic          frame_start_q;

    assign sample          = (presc == '0) && (step == '0);
    assign bus.frame_start = frame_start_q;

    // Free-running frame counters and the registered frame-start pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc         <= '0;
            step          <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= sample;
            if (presc == PW'(PRESCALE - 1)) begin
                presc <= '0;
                if (step == SW'(STEPS - 1)) begin
                    step <= '0;
                end else begin
                    step <= step + SW'(1);
                end
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    wheel_pwm_channel #(
        .WIDTH_CMD       (WIDTH_CMD),
        .DEADTIME_FRAMES (DEADTIME_FRAMES)
    ) u_left (
        .clk    (clk),
        .reset  (reset),
        .enable (bus.enable),
        .sample (sample),
        .step   (step),
        .cmd    (bus.wheel_left),
        .pwm    (bus.pwm_left),
        .dir    (bus.dir_left),
        .state  (bus.state_left)
    );

    wheel_pwm_channel #(
        .WIDTH_CMD       (WIDTH_CMD),
        .DEADTIME_FRAMES (DEADTIME_FRAMES)
    ) u_right (
        .clk    (clk),
        .reset  (reset),
        .enable (bus.enable),
        .sample (sample),
        .step   (step),
        .cmd    (bus.wheel_right),
        .pwm    (bus.pwm_right),
        .dir    (bus.dir_right),
        .state  (bus.state_right)
    );

endmodule

// File: tb/tb_wheel_motor_driver.sv
// Bench for wheel_motor_driver at WIDTH_CMD=4, PRESCALE=4, DEADTIME_FRAMES=1.
module tb_wheel_motor_driver;
    import wheel_motor_driver_pkg::*;

    localparam int W     = 4;
    localparam int P     = 4;
    localparam int DT    = 1;
    localparam int STEPS = 7;
    localparam int FRAME = 28;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wheel_motor_driver_if #(.WIDTH_CMD(W)) bus ();

    wheel_motor_driver #(
        .WIDTH_CMD       (W),
        .PRESCALE        (P),
        .DEADTIME_FRAMES (DT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame-level view: edges counted since reset release, position in frame
    // is edge count mod FRAME; commands matter only at position 0.
    int edge_cnt;
    int m_dir[2];
    int m_in_dead[2];
    int m_dead[2];
    int m_mag[2];
    int exp_pwm[2];
    int exp_fs;
    int hi[2];

    function automatic int sval(input logic [W-1:0] c);
        return int'($signed(c));
    endfunction

    task automatic model_reset();
        edge_cnt = 0;
        exp_fs   = 0;
        for (int i = 0; i < 2; i++) begin
            m_dir[i] = 0; m_in_dead[i] = 0; m_dead[i] = 0; m_mag[i] = 0; exp_pwm[i] = 0;
        end
    endtask

    task automatic model_edge();
        int pos, c, mag, neg;
        pos = edge_cnt % FRAME;
        for (int i = 0; i < 2; i++) begin
            if (pos == 0) begin
                c   = (i == 0) ? sval(bus.wheel_left) : sval(bus.wheel_right);
                neg = (c < 0) ? 1 : 0;
                mag = (c < 0) ? ((-c > STEPS) ? STEPS : -c) : c;
                if (m_in_dead[i] == 0) begin
                    if (mag != 0 && neg != m_dir[i]) begin
                        m_in_dead[i] = 1; m_dead[i] = DT; m_mag[i] = 0;
                    end else begin
                        m_mag[i] = mag;
                    end
                end else begin
                    m_dead[i]--;
                    if (m_dead[i] <= 0) begin
                        m_in_dead[i] = 0;
                        if (mag != 0 && neg != m_dir[i]) m_dir[i] = 1 - m_dir[i];
                        m_mag[i] = mag;
                    end
                end
            end
            exp_pwm[i] = (bus.enable && m_in_dead[i] == 0 && pos < m_mag[i] * P) ? 1 : 0;
        end
        exp_fs = (pos == 0) ? 1 : 0;
        edge_cnt++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("pwm_left",    32'(bus.pwm_left),    32'(exp_pwm[0]));
        check("pwm_right",   32'(bus.pwm_right),   32'(exp_pwm[1]));
        check("dir_left",    32'(bus.dir_left),    32'(m_dir[0]));
        check("dir_right",   32'(bus.dir_right),   32'(m_dir[1]));
        check("frame_start", 32'(bus.frame_start), 32'(exp_fs));
        check("dead_left",   32'(bus.state_left == DEAD),  32'(m_in_dead[0]));
        check("dead_right",  32'(bus.state_right == DEAD), 32'(m_in_dead[1]));
        hi[0] += int'(bus.pwm_left);
        hi[1] += int'(bus.pwm_right);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic clr();
        hi[0] = 0; hi[1] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_pwm_left",    32'(bus.pwm_left),    0);
        check("rst_pwm_right",   32'(bus.pwm_right),   0);
        check("rst_dir_left",    32'(bus.dir_left),    0);
        check("rst_dir_right",   32'(bus.dir_right),   0);
        check("rst_frame_start", 32'(bus.frame_start), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.enable      = 1'b1;
        bus.wheel_left  = '0;
        bus.wheel_right = '0;
        clr();
        do_reset();

        // +3: 12 of 28 high, forward
        bus.wheel_left = 4'sd3;
        clr(); run(FRAME);
        check("duty_p3_f1", hi[0], 12);
        clr(); run(FRAME);
        check("duty_p3_f2", hi[0], 12);
        check("dir_p3", 32'(bus.dir_left), 0);

        // -8: one dead frame, then reverse at full duty
        bus.wheel_left = 4'b1000;
        clr(); run(FRAME);
        check("m8_dead_frame", hi[0], 0);
        clr(); run(FRAME);
        check("m8_full", hi[0], 28);
        check("m8_dir", 32'(bus.dir_left), 1);

        // right +5 then -5 just before a sample edge; left unaffected
        bus.wheel_right = 4'sd5;
        clr(); run(FRAME);
        check("r_p5", hi[1], 20);
        bus.wheel_right = -4'sd5;
        clr(); run(FRAME);
        check("r_dead_frame", hi[1], 0);
        check("r_left_kept1", hi[0], 28);
        clr(); run(FRAME);
        check("r_m5", hi[1], 20);
        check("r_dir", 32'(bus.dir_right), 1);
        check("r_left_kept2", hi[0], 28);

        // reversal cancelled during the dead frame
        bus.wheel_right = '0;
        do_reset();
        bus.wheel_left = 4'sd5;
        clr(); run(FRAME);
        check("cancel_pre", hi[0], 20);
        bus.wheel_left = -4'sd5;
        clr(); run(10);
        bus.wheel_left = 4'sd5;
        run(FRAME - 10);
        check("cancel_dead", hi[0], 0);
        clr(); run(FRAME);
        check("cancel_after", hi[0], 20);
        check("cancel_dir", 32'(bus.dir_left), 0);

        // mid-frame command change takes effect next frame
        bus.wheel_left  = 4'sd2;
        bus.wheel_right = -4'sd3;
        clr(); run(10);
        bus.wheel_left = 4'sd6;
        run(FRAME - 10);
        check("midchg_f1", hi[0], 8);
        clr(); run(FRAME);
        check("midchg_f2", hi[0], 24);
        check("midchg_rdir", 32'(bus.dir_right), 1);

        // reset at clock 5 of a frame, then frame_start on the first cycle
        run(5);
        check("pre_rst_pwm", 32'(bus.pwm_left), 1);
        do_reset();
        cycle();
        check("fs_after_reset", 32'(bus.frame_start), 1);
        run(FRAME - 1);

        // enable dropped mid-pulse, then restored
        clr(); run(3);
        bus.enable = 1'b0;
        cycle();
        check("en_low_pwm", 32'(bus.pwm_left), 0);
        check("en_low_dir", 32'(bus.dir_left), 0);
        run(5);
        bus.enable = 1'b1;
        cycle();
        check("en_back_pwm", 32'(bus.pwm_left), 1);
        run(FRAME - 10);

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            bus.wheel_left  = 4'($urandom_range(0, 15));
            bus.wheel_right = 4'($urandom_range(0, 15));
            for (int k = 0; k < FRAME; k++) begin
                if ($urandom_range(0, 19) == 0) bus.wheel_left  = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 19) == 0) bus.wheel_right = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 15) == 0) bus.enable = ~bus.enable;
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wheel_motor_driver.md
WHEEL_MOTOR_DRIVER -- requirements
Module: wheel_motor_driver

Interface
REQ-001 Parameter WIDTH_CMD, default 4, SHALL set the signed wheel-command width.
REQ-002 Parameter PRESCALE, default 256, SHALL set the clocks per duty step.
REQ-003 Parameter DEADTIME_FRAMES, default 1, SHALL set the PWM frames held low on a direction reversal.
REQ-004 clk  input  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-low reset: asserted when 0.
REQ-006 enable  input  1  SHALL gate all PWM outputs: 1 means drive, 0 means force low.
REQ-007 wheel_left  input  WIDTH_CMD  SHALL carry the signed left-wheel command in two's complement.
REQ-008 wheel_right  input  WIDTH_CMD  SHALL carry the signed right-wheel command in two's complement.
REQ-009 pwm_left, pwm_right  output  1 each  SHALL be the registered motor PWM outputs.
REQ-010 dir_left, dir_right  output  1 each  SHALL be the registered direction outputs: 0 means forward, 1 means reverse.
REQ-011 frame_start  output  1  SHALL be a registered one-cycle pulse marking each command sample point.

Function
REQ-012 STEPS SHALL equal 2^(WIDTH_CMD-1)-1; FRAME SHALL equal STEPS*PRESCALE clocks.
REQ-013 Counters:
  - a prescale counter SHALL run 0..PRESCALE-1 and wrap to 0;
  - a step counter SHALL advance on each prescale wrap and run 0..STEPS-1, then wrap to 0;
  - both counters SHALL run continuously, independent of enable.
REQ-014 Sample edge: each edge at which both counters equal 0 is a sample edge.
  - frame_start SHALL be high for exactly the cycle following each sample edge;
  - period SHALL be FRAME clocks.
REQ-015 Command sampling: each channel SHALL sample its command only on sample edges; changes between sample edges SHALL have no effect until the next sample edge.
REQ-016 Magnitude: magnitude SHALL be |cmd|, with the most-negative code saturated to STEPS (for example, -8 gives 7 at WIDTH_CMD=4).
REQ-017 Duty: in DRIVE, pwm SHALL be high for the first mag*PRESCALE clocks of the frame, starting the cycle after the sample edge (latency 1), and low for the rest of the frame.
  - mag 0 SHALL give a constant low output;
  - mag STEPS SHALL give a constant high output.
REQ-018 Per-channel FSM states SHALL be DRIVE and DEAD; the reset state SHALL be DRIVE.
REQ-019 DRIVE to DEAD: at a sample edge where mag is nonzero and sign(cmd) differs from dir, the channel SHALL enter DEAD and load its dead counter with DEADTIME_FRAMES.
REQ-020 In DEAD:
  - pwm SHALL be low and dir SHALL be held;
  - the dead counter SHALL decrement at each sample edge.
REQ-021 DEAD exit: at the sample edge where the dead counter reaches 0, the channel SHALL re-sample its command.
  - if sign(cmd) still opposes dir and mag is nonzero, dir SHALL flip and the channel SHALL enter DRIVE, using the new duty in that same frame;
  - otherwise dir SHALL be held and the channel SHALL enter DRIVE with the sampled command.
REQ-022 A zero command SHALL never change dir.
REQ-023 Enable low:
  - while enable is 0, pwm_left and pwm_right SHALL go low on the next clock edge;
  - the FSMs, dir and the counters SHALL continue unaffected;
  - after enable returns to 1, PWM SHALL resume on the next clock edge using the current frame's latched duty and state.
REQ-024 Channels SHALL be fully independent; simultaneous reversals on both wheels SHALL each follow REQ-019..021.

Reset
REQ-025 While reset is 0, all outputs, counters, latched magnitudes and dead counters SHALL be 0, and the FSMs SHALL be in DRIVE, asynchronously and immediately.
REQ-026 After release, the first rising edge SHALL be a sample edge; frame_start SHALL pulse on the following cycle.
REQ-027 Reset asserted mid-frame or mid-DEAD SHALL abort the frame with no partial pulse, and dir SHALL return to 0.

Structure
REQ-028 A shared package SHALL hold the FSM state encodings (DRIVE, DEAD) and the STEPS/FRAME derivation functions.
REQ-029 Per-wheel logic (sampling, saturation, FSM, PWM compare) SHALL be a sub-module wheel_pwm_channel, instantiated twice.
REQ-030 The shared counters and frame_start SHALL reside in the top level.

Verification (WIDTH_CMD=4, PRESCALE=4, DEADTIME_FRAMES=1, so FRAME=28 clocks)
REQ-031 wheel_left=+3, enable=1: pwm_left SHALL be high 12 of every 28 clocks, starting 1 cycle after each sample edge, and dir_left SHALL be 0.
REQ-032 Starting from dir_left=0, wheel_left=-8: there SHALL be one frame of pwm_left low, then dir_left=1 and pwm_left high for all 28 clocks of each subsequent frame.
REQ-033 Starting from wheel_right=+5 in DRIVE, switch to -5 just before a sample edge: there SHALL be one full frame low, then dir_right=1 and pwm_right high 20 of 28 clocks; the left channel SHALL be unaffected.
REQ-034 Reversal cancel: with wheel_left=+5 (dir_left=0), change to -5 before a sample edge, then back to +5 during DEAD: after one low frame, dir_left SHALL stay 0 and pwm_left SHALL be high 20 of 28 clocks.
REQ-035 Mid-frame change: wheel_left changes from +2 to +6 at clock 10 of a frame; that frame SHALL have 8 clocks high and the next SHALL have 24.
REQ-036 Reset and enable: asserting reset at clock 5 of a frame SHALL force all outputs to 0 immediately, and after release frame_start SHALL pulse on cycle 2; deasserting enable mid-pulse SHALL drop pwm on the next clock with dir unchanged.
